sd_sector_buffer: RTL
=====================

// Module: sd_sector_buffer
// PURPOSE
//  Parametrised SD sector assembly buffer: accepts DATA_W-bit words at word addresses and builds one
//  DEPTH*DATA_W-bit sector (default 128 x 32 = 4096 bits = 512 B), exposed flat to the SD controller.
//  Adds an optional bit reversal, per-word valid tracking, a block-full flag, a clear command and a
//  registered word read-back port.
//  Sits between the CPU/cache side and the SD write engine in the storage path.
// PARAMETERS
//  DATA_W   32   word width in bits
//  DEPTH    128  words per sector; power of two, >= 2
//  ADDR_W   7    $clog2(DEPTH); localparam, not user-set
//  BIT_REV  1    1: din[i] stored at word bit DATA_W-1-i; 0: stored unchanged
// PORTS
//  clk        in   1              single clock, rising edge
//  reset      in   1              asynchronous, active-low; all state cleared while low
//  clear      in   1              sync clear of sector data, valid map, count and FSM
//  we         in   1              write request; sampled only in IDLE
//  addr       in   ADDR_W         word slot for the write
//  din        in   DATA_W         write data
//  busy       out  1              1 when not IDLE; we ignored while busy
//  write_end  out  1              1-cycle pulse when a write has committed
//  rd_addr    in   ADDR_W         read-back word slot
//  rd_data    out  DATA_W         registered stored word at rd_addr; word bit order, no re-reversal
//  sector     out  DEPTH*DATA_W   flat sector; slot k = sector[k*DATA_W +: DATA_W]
//  valid_map  out  DEPTH          bit k set once slot k has been written since last clear
//  word_cnt   out  ADDR_W+1       number of set bits in valid_map (0..DEPTH)
//  full       out  1              word_cnt == DEPTH
//  state      out  2              current FSM state (debug)
// BEHAVIOUR
//  Reset (reset low): sector, rd_data, valid_map, word_cnt = 0; full, write_end, busy = 0; state IDLE.
//  FSM: IDLE(0) -> PREPARE(1) -> WRITE_END(2) -> IDLE; encoding 3 unused, recovers to IDLE.
//   IDLE:      we=1 and clear=0 -> latch addr, din (optionally reversed) -> PREPARE; else stay.
//   PREPARE:   latched word written into slot; valid_map[addr] set; word_cnt += 1 only if bit was 0.
//   WRITE_END: write_end=1 for exactly this cycle; -> IDLE.
//  Latency: we sampled at edge N -> slot and valid_map updated at edge N+1 -> write_end high during
//   cycle after edge N+1 and low after edge N+2. Next write accepted at edge N+3 at earliest.
//  Write data and addr are latched at acceptance; later changes to din/addr do not affect that write.
//  Rewriting a valid slot overwrites the data; word_cnt and full are unchanged.
//  clear (any state): at next edge sector, valid_map, word_cnt = 0 and FSM -> IDLE.
//   A write in progress is discarded and no write_end is issued. clear beats we in the same cycle.
//  full is registered from word_cnt, with no extra cycle of delay; it stays 1 until clear or reset.
//  Read port: rd_data <= slot[rd_addr] every edge, in every state.
//   A read of the slot being written in PREPARE returns the old value (read-before-write).
//  Widths: word_cnt is ADDR_W+1 bits so DEPTH is representable; no wrap.
//  Only registers drive outputs; sector is not assembled combinationally.
// STRUCTURE
//  Shared package sd_pkg: FSM state localparams (SDB_IDLE, SDB_PREPARE, SDB_WRITE_END) and
//   SD_SECTOR_BITS = 4096.
//  Sub-module sd_bit_reverse #(DATA_W): combinational word reversal, instantiated on the din path.
//   With BIT_REV=0 it is bypassed by a generate block.
//  Sector storage is a DEPTH-entry register array with per-slot write enable, flattened to sector.
// TESTING
//  1 reset low mid-PREPARE -> all outputs 0, state 0; no write_end after release.
//  2 BIT_REV=1, we, addr=0, din=32'h0000_0001 -> sector[31:0]=32'h8000_0000.
//    write_end pulses exactly 1 cycle, 2 edges after acceptance; word_cnt=1.
//  3 BIT_REV=0, addr=127, din=32'hDEAD_BEEF -> sector[4095:4064]=32'hDEAD_BEEF.
//    rd_addr=127 -> rd_data=32'hDEAD_BEEF one edge later.
//  4 write all 128 slots, then rewrite slot 5 -> full=1 after 128th write; word_cnt stays 128.
//  5 we held high continuously -> one accepted write per 3 cycles; busy=1 in PREPARE and WRITE_END.
//  6 clear asserted in PREPARE with we=1 -> no write_end; slot unchanged.
//    valid_map=0, word_cnt=0, full=0, state IDLE at next edge.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector assembly path: write FSM states and sector geometry.
package sd_pkg;

   typedef enum logic [1:0] {
      SDB_IDLE      = 2'd0,
      SDB_PREPARE   = 2'd1,
      SDB_WRITE_END = 2'd2,
      SDB_UNUSED    = 2'd3
   } sdb_state_e;

   localparam int SD_SECTOR_BITS = 4096;

endpackage

// File: rtl/sd_bit_reverse.sv
// Combinational word bit reversal: input bit i appears at output bit DATA_W-1-i.
module sd_bit_reverse #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data
);

   for (genvar i = 0; i < DATA_W; i++) begin : g_rev
      assign o_data[DATA_W-1-i] = i_data[i];
   end

endmodule

// File: rtl/sd_sector_buffer.sv
// SD sector assembly buffer: collects words into one flat sector with valid tracking,
// a full flag, a clear command and a registered read-back port.
module sd_sector_buffer
   import sd_pkg::*;
#(
   parameter int  DATA_W  = 32,
   parameter int  DEPTH   = 128,
   parameter int  BIT_REV = 1,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [DATA_W-1:0]       din,
   output logic                    busy,
   output logic                    write_end,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [DATA_W-1:0]       rd_data,
   output logic [DEPTH*DATA_W-1:0] sector,
   output logic [DEPTH-1:0]        valid_map,
   output logic [ADDR_W:0]         word_cnt,
   output logic                    full,
   output logic [1:0]              state
);

   sdb_state_e          r_state;
   sdb_state_e          w_next;
   logic                w_accept;
   logic                w_commit;
   logic                r_busy;
   logic                r_writeEnd;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic [DATA_W-1:0]   w_din;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_rdData;
   logic [DEPTH-1:0]    r_valid;
   logic [ADDR_W:0]     r_cnt;
   logic [ADDR_W:0]     w_cntInc;
   logic                r_full;

   if (BIT_REV != 0) begin : g_rev
      sd_bit_reverse #(.DATA_W(DATA_W)) u_bitReverse (
         .i_data (din),
         .o_data (w_din)
      );
   end else begin : g_noRev
      assign w_din = din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= SDB_IDLE;
      else        r_state <= w_next;
   end

   // clear has priority over everything, so an in-flight write never commits.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_commit = 1'b0;
      if (clear) begin
         w_next = SDB_IDLE;
      end else begin
         case (r_state)
            SDB_IDLE: begin
               if (we) begin
                  w_accept = 1'b1;
                  w_next   = SDB_PREPARE;
               end
            end
            SDB_PREPARE: begin
               w_commit = 1'b1;
               w_next   = SDB_WRITE_END;
            end
            SDB_WRITE_END: w_next = SDB_IDLE;
            default:       w_next = SDB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy     <= 1'b0;
         r_writeEnd <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
      end else begin
         r_busy     <= (w_next != SDB_IDLE);
         r_writeEnd <= (w_next == SDB_WRITE_END);
         if (w_accept) begin
            r_addr <= addr;
            r_data <= w_din;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      end else if (clear) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      end else if (w_commit) begin
         r_mem[r_addr] <= r_data;
      end
   end

   // Reads sample the array before this edge's commit, giving read-before-write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_rdData <= '0;
      else        r_rdData <= r_mem[rd_addr];
   end

   assign w_cntInc = r_cnt + (ADDR_W+1)'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         r_cnt   <= '0;
         r_full  <= 1'b0;
      end else if (clear) begin
         r_valid <= '0;
         r_cnt   <= '0;
         r_full  <= 1'b0;
      end else if (w_commit && !r_valid[r_addr]) begin
         r_valid[r_addr] <= 1'b1;
         r_cnt           <= w_cntInc;
         r_full          <= (w_cntInc == (ADDR_W+1)'(DEPTH));
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_flat
      assign sector[k*DATA_W +: DATA_W] = r_mem[k];
   end

   assign busy      = r_busy;
   assign write_end = r_writeEnd;
   assign rd_data   = r_rdData;
   assign valid_map = r_valid;
   assign word_cnt  = r_cnt;
   assign full      = r_full;
   assign state     = r_state;

endmodule
